ddrio_rx_align_ctrl: RTL

//  Word-alignment trainer for one ddrio_x2 pair (two 1:8 DDR lanes sharing update/align logic).

---
 rtl/ddrio_rx_align_ctrl_if.sv | 29 ++
 rtl/ddrio_rx_align_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ddrio_rx_align_ctrl_if.sv
// Control/data bundle between the PHY init sequencer, one ddrio_x2 pair and the alignment trainer.
// The trainer uses the slave view; the sequencer/PHY side (or a bench) uses the master view.
interface ddrio_rx_align_ctrl_if #(
  parameter int MAX_SLIPS = 8
);
  localparam int SLIP_W = $clog2(MAX_SLIPS + 1);

  logic              start;
  logic [7:0]        q_0;
  logic [7:0]        q_1;
  logic              align_rst_ol;
  logic              align_il;
  logic              align_ol;
  logic              cken;
  logic              busy;
  logic              done;
  logic              fail;
  logic [SLIP_W-1:0] slip_cnt;

  modport master (
    output start, q_0, q_1,
    input  align_rst_ol, align_il, align_ol, cken, busy, done, fail, slip_cnt
  );

  modport slave (
    input  start, q_0, q_1,
    output align_rst_ol, align_il, align_ol, cken, busy, done, fail, slip_cnt
  );
endinterface

// File: rtl/ddrio_rx_align_ctrl.sv
// Word-alignment trainer for one ddrio_x2 pair: resets the pair, then bit-slips both lanes
// until the training pattern is seen on both for MATCH_CNT consecutive words, or gives up.
module ddrio_rx_align_ctrl #(
  parameter int         RST_CYCLES    = 16,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         MATCH_CNT     = 4,
  parameter int         MAX_SLIPS     = 8,
  parameter logic [7:0] PATTERN       = 8'hB4
) (
  input  logic                 gsclk,
  input  logic                 rst_n,
  ddrio_rx_align_ctrl_if.slave bus
);

  localparam int SLIP_W  = $clog2(MAX_SLIPS + 1);
  localparam int TMR_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int MCH_W   = $clog2(MATCH_CNT + 1);

  localparam logic [TMR_W-1:0]  RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [MCH_W-1:0]  MATCH_LAST  = MCH_W'(MATCH_CNT - 1);
  localparam logic [SLIP_W-1:0] SLIP_LIMIT  = SLIP_W'(MAX_SLIPS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_SETTLE_S,
    ST_LOCKED,
    ST_FAILED
  } state_t;

  state_t            state_reg, state_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic [MCH_W-1:0]  match_reg, match_next;
  logic [SLIP_W-1:0] slip_cnt_reg, slip_cnt_next;
  logic              align_rst_reg, align_rst_next;
  logic              align_il_reg, align_il_next;
  logic              cken_reg, cken_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              fail_reg, fail_next;
  logic              hit;

  assign hit = (bus.q_0 == PATTERN) && (bus.q_1 == PATTERN);

  always_ff @(posedge gsclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      match_reg     <= '0;
      slip_cnt_reg  <= '0;
      align_rst_reg <= 1'b1;
      align_il_reg  <= 1'b0;
      cken_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      match_reg     <= match_next;
      slip_cnt_reg  <= slip_cnt_next;
      align_rst_reg <= align_rst_next;
      align_il_reg  <= align_il_next;
      cken_reg      <= cken_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      fail_reg      <= fail_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = '0;
    match_next    = match_reg;
    slip_cnt_next = slip_cnt_reg;
    done_next     = done_reg;
    fail_next     = fail_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next    = ST_RESET;
          done_next     = 1'b0;
          fail_next     = 1'b0;
          slip_cnt_next = '0;
        end
      end
      ST_RESET: begin
        if (timer_reg == RST_LAST) state_next = ST_SETTLE;
        else                       timer_next = timer_reg + 1'b1;
      end
      ST_SETTLE, ST_SETTLE_S: begin
        if (timer_reg == SETTLE_LAST) state_next = ST_CHECK;
        else                          timer_next = timer_reg + 1'b1;
      end
      ST_CHECK: begin
        if (hit) begin
          if (match_reg == MATCH_LAST) state_next = ST_LOCKED;
          else                         match_next = match_reg + 1'b1;
        end else begin
          match_next = '0;
          // A hit at the slip limit still counts; only a miss there gives up.
          if (slip_cnt_reg == SLIP_LIMIT) begin
            state_next = ST_FAILED;
          end else begin
            state_next    = ST_SLIP;
            slip_cnt_next = slip_cnt_reg + 1'b1;
          end
        end
      end
      ST_SLIP:   state_next = ST_SETTLE_S;
      ST_LOCKED: begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_FAILED: begin
        fail_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase

    if (state_next != state_reg) begin
      timer_next = '0;
      match_next = '0;
    end

    // Outputs are decoded from the next state so they are registered and glitch-free.
    align_rst_next = align_rst_reg;
    cken_next      = cken_reg;
    if (state_next == ST_RESET) begin
      align_rst_next = 1'b1;
      cken_next      = 1'b0;
    end else if (state_next == ST_SETTLE) begin
      align_rst_next = 1'b0;
      cken_next      = 1'b1;
    end
    align_il_next = (state_next == ST_SLIP);
    busy_next     = (state_next != ST_IDLE);
  end

  assign bus.align_rst_ol = align_rst_reg;
  assign bus.align_il     = align_il_reg;
  assign bus.align_ol     = 1'b0;
  assign bus.cken         = cken_reg;
  assign bus.busy         = busy_reg;
  assign bus.done         = done_reg;
  assign bus.fail         = fail_reg;
  assign bus.slip_cnt     = slip_cnt_reg;

endmodule
